// File: rtl/tile_game_pkg.sv
// rtl/tile_game_pkg.sv - action codes and FSM states shared by controller, renderer and bench
package tile_game_pkg;

   localparam logic [1:0] ACT_HIDDEN   = 2'b00;
   localparam logic [1:0] ACT_CURSOR   = 2'b01;
   localparam logic [1:0] ACT_REVEALED = 2'b10;
   localparam logic [1:0] ACT_MATCHED  = 2'b11;

   typedef enum logic [2:0] {
      SEL1  = 3'd0,
      SEL2  = 3'd1,
      CHECK = 3'd2,
      HOLD  = 3'd3,
      WIN   = 3'd4
   } tile_state_e;

endpackage

// File: rtl/tile_action_ctrl_if.sv
// rtl/tile_action_ctrl_if.sv - button pulses, tile colours and renderer-facing status of the tile controller
interface tile_action_ctrl_if #(
   parameter int NUM_TILES = 4,
   parameter int COLOR_W   = 2
);
   localparam int IDX_W = $clog2(NUM_TILES);

   logic                         move_pulse;
   logic                         select_pulse;
   logic [NUM_TILES*COLOR_W-1:0] tile_color;
   logic [2*NUM_TILES-1:0]       action;
   logic [IDX_W-1:0]             cursor;
   logic                         busy;
   logic                         winscreen;
   logic [7:0]                   attempts;

   // driver side: debouncers / bench
   modport master (
      output move_pulse, select_pulse, tile_color,
      input  action, cursor, busy, winscreen, attempts
   );

   // controller side
   modport slave (
      input  move_pulse, select_pulse, tile_color,
      output action, cursor, busy, winscreen, attempts
   );

endinterface

// File: rtl/mismatch_timer.sv
// rtl/mismatch_timer.sv - loadable down-counter timing how long a mismatched pair stays revealed
module mismatch_timer #(
   parameter int HOLD_CYCLES = 25_000_000
) (
   input  logic clk25MHz,
   input  logic rst_n,
   input  logic load,
   output logic done
);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // load the full hold length, then count down to zero and park there
   always_ff @(posedge clk25MHz) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(HOLD_CYCLES);
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   // done marks the last of the HOLD_CYCLES counted cycles, so the owner leaves on that edge
   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/tile_action_ctrl.sv
// rtl/tile_action_ctrl.sv - tile state controller; TILE_ACTION_ATTEMPTS_EN enables the attempts counter
module tile_action_ctrl
   import tile_game_pkg::*;
#(
   parameter int NUM_TILES     = 4,
   parameter int COLOR_W       = 2,
   parameter int MISMATCH_HOLD = 25_000_000
) (
   input  logic               clk25MHz,
   input  logic               rst_n,
   tile_action_ctrl_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_TILES);

   localparam logic [2:0] ST_SEL1  = SEL1;
   localparam logic [2:0] ST_SEL2  = SEL2;
   localparam logic [2:0] ST_CHECK = CHECK;
   localparam logic [2:0] ST_HOLD  = HOLD;
   localparam logic [2:0] ST_WIN   = WIN;

   logic [2:0]             state;
   logic [NUM_TILES-1:0]   revealed;
   logic [NUM_TILES-1:0]   matched;
   logic [NUM_TILES-1:0]   matched_next;
   logic [IDX_W-1:0]       cursor_q;
   logic [IDX_W-1:0]       first_q;
   logic [IDX_W-1:0]       second_q;
   logic                   win_q;
   logic                   cur_hidden;
   logic                   colors_equal;
   logic [COLOR_W-1:0]     color_first;
   logic [COLOR_W-1:0]     color_second;
   logic                   timer_load;
   logic                   timer_done;
   logic [2*NUM_TILES-1:0] action_d;

   // first index after 'from' (wrapping) whose mask bit is clear; 'from' if none
   function automatic logic [IDX_W-1:0] next_unmatched(input logic [IDX_W-1:0] from,
                                                       input logic [NUM_TILES-1:0] mask);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = from;
      found = 1'b0;
      for (int k = 1; k <= NUM_TILES; k++) begin
         idx = (int'(from) + k) % NUM_TILES;
         if (!found && !mask[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign cur_hidden   = !revealed[cursor_q] && !matched[cursor_q];
   assign color_first  = bus.tile_color[int'(first_q)*COLOR_W +: COLOR_W];
   assign color_second = bus.tile_color[int'(second_q)*COLOR_W +: COLOR_W];
   assign colors_equal = (color_first == color_second);
   assign timer_load   = (state == ST_CHECK) && !colors_equal;

   // matched mask as it will be if the current pair turns out equal
   always_comb begin
      matched_next           = matched;
      matched_next[first_q]  = 1'b1;
      matched_next[second_q] = 1'b1;
   end

   mismatch_timer #(
      .HOLD_CYCLES (MISMATCH_HOLD)
   ) u_mismatch_timer (
      .clk25MHz (clk25MHz),
      .rst_n    (rst_n),
      .load     (timer_load),
      .done     (timer_done)
   );

   // game sequencing: picks, compare, mismatch hold and terminal win
   always_ff @(posedge clk25MHz) begin
      if (!rst_n) begin
         state    <= ST_SEL1;
         revealed <= '0;
         matched  <= '0;
         cursor_q <= '0;
         first_q  <= '0;
         second_q <= '0;
         win_q    <= 1'b0;
      end else begin
         case (state)
            ST_SEL1, ST_SEL2: begin
               // select wins over a simultaneous move, even when the select is ignored
               if (bus.select_pulse) begin
                  if (cur_hidden) begin
                     revealed[cursor_q] <= 1'b1;
                     if (state == ST_SEL1) begin
                        first_q <= cursor_q;
                        state   <= ST_SEL2;
                     end else begin
                        second_q <= cursor_q;
                        state    <= ST_CHECK;
                     end
                  end
               end else if (bus.move_pulse) begin
                  cursor_q <= next_unmatched(cursor_q, matched);
               end
            end
            ST_CHECK: begin
               if (colors_equal) begin
                  matched            <= matched_next;
                  revealed[first_q]  <= 1'b0;
                  revealed[second_q] <= 1'b0;
                  cursor_q           <= next_unmatched(second_q, matched_next);
                  if (&matched_next) begin
                     state <= ST_WIN;
                     win_q <= 1'b1;
                  end else begin
                     state <= ST_SEL1;
                  end
               end else begin
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (timer_done) begin
                  revealed[first_q]  <= 1'b0;
                  revealed[second_q] <= 1'b0;
                  state              <= ST_SEL1;
               end
            end
            ST_WIN: begin
               state <= ST_WIN;
            end
            default: begin
               state <= ST_SEL1;
            end
         endcase
      end
   end

   // per-tile action code: matched over revealed over cursor over hidden
   always_comb begin
      action_d = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (matched[i])
            action_d[2*i +: 2] = ACT_MATCHED;
         else if (revealed[i])
            action_d[2*i +: 2] = ACT_REVEALED;
         else if (cursor_q == IDX_W'(i))
            action_d[2*i +: 2] = ACT_CURSOR;
         else
            action_d[2*i +: 2] = ACT_HIDDEN;
      end
   end

`ifdef TILE_ACTION_ATTEMPTS_EN
   logic       enter_check;
   logic [7:0] attempts_q;

   assign enter_check = (state == ST_SEL2) && bus.select_pulse && cur_hidden;

   // saturating count of pair attempts, one per CHECK entry
   always_ff @(posedge clk25MHz) begin
      if (!rst_n) begin
         attempts_q <= 8'd0;
      end else if (enter_check && (attempts_q != 8'hFF)) begin
         attempts_q <= attempts_q + 8'd1;
      end
   end

   assign bus.attempts = attempts_q;
`else
   assign bus.attempts = 8'd0;
`endif

   assign bus.action    = action_d;
   assign bus.cursor    = cursor_q;
   assign bus.busy      = (state == ST_CHECK) || (state == ST_HOLD);
   assign bus.winscreen = win_q;

endmodule

// File: tb/tb_tile_action_ctrl.sv
// tb/tb_tile_action_ctrl.sv - directed bench for tile_action_ctrl, 4 tiles, hold 4, colours {0,1,1,0}
module tb_tile_action_ctrl;

   logic clk25MHz = 1'b0;
   logic rst_n    = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

`ifdef TILE_ACTION_ATTEMPTS_EN
   localparam bit ATT_EN = 1'b1;
`else
   localparam bit ATT_EN = 1'b0;
`endif

   tile_action_ctrl_if #(.NUM_TILES(4), .COLOR_W(2)) bus ();

   tile_action_ctrl #(
      .NUM_TILES     (4),
      .COLOR_W       (2),
      .MISMATCH_HOLD (4)
   ) dut (
      .clk25MHz (clk25MHz),
      .rst_n    (rst_n),
      .bus      (bus.slave)
   );

   always #20 clk25MHz = ~clk25MHz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic expect_state(input string tag, input logic [7:0] act, input int cur, input logic bsy);
      check({tag, ".action"}, 32'(bus.action), 32'(act));
      check({tag, ".cursor"}, 32'(bus.cursor), 32'(cur));
      check({tag, ".busy"},   32'(bus.busy),   32'(bsy));
   endtask

   function automatic logic [7:0] att(input int n);
      return ATT_EN ? 8'(n) : 8'd0;
   endfunction

   // called at a falling edge (or time 0); returns at the falling edge after the reset edge
   task automatic apply_reset();
      rst_n = 1'b0;
      @(negedge clk25MHz);
      rst_n = 1'b1;
   endtask

   task automatic pulse(input logic mv, input logic sel);
      bus.move_pulse   = mv;
      bus.select_pulse = sel;
      @(negedge clk25MHz);
      bus.move_pulse   = 1'b0;
      bus.select_pulse = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk25MHz);
   endtask

   initial begin
      bus.move_pulse   = 1'b0;
      bus.select_pulse = 1'b0;
      bus.tile_color   = 8'b00_01_01_00;

      // reset state
      apply_reset();
      expect_state("reset", 8'h01, 0, 1'b0);
      check("reset.winscreen", 32'(bus.winscreen), 32'd0);
      check("reset.attempts",  32'(bus.attempts),  32'd0);

      // mismatch 0/1, with ignored reselect and move+select in the same cycle
      pulse(1'b0, 1'b1);
      expect_state("pick0", 8'h02, 0, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("reselect_revealed", 8'h02, 0, 1'b0);
      pulse(1'b1, 1'b0);
      expect_state("move_to1", 8'h06, 1, 1'b0);
      pulse(1'b1, 1'b1);
      expect_state("move_and_select", 8'h0A, 1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle();
         expect_state("hold", 8'h0A, 1, 1'b1);
      end
      idle();
      expect_state("hold_release", 8'h04, 1, 1'b0);
      check("mismatch.attempts", 32'(bus.attempts), 32'(att(1)));

      // cursor wraps 3 -> 0, then match 0/3
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      expect_state("wrap_3_to_0", 8'h01, 0, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("pick0_again", 8'h02, 0, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      expect_state("cursor_at3", 8'h42, 3, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("match_check", 8'h82, 3, 1'b1);
      idle();
      expect_state("match_result", 8'hC7, 1, 1'b0);
      check("match.winscreen", 32'(bus.winscreen), 32'd0);

      // cursor skips matched tiles 3 and 0 when wrapping
      pulse(1'b1, 1'b0);
      expect_state("move_to2", 8'hD3, 2, 1'b0);
      pulse(1'b1, 1'b0);
      expect_state("skip_matched_wrap", 8'hC7, 1, 1'b0);

      // last pair 1/2 -> win
      pulse(1'b0, 1'b1);
      expect_state("pick1", 8'hCB, 1, 1'b0);
      pulse(1'b1, 1'b0);
      expect_state("move_to2b", 8'hDB, 2, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("last_check", 8'hEB, 2, 1'b1);
      check("last_check.winscreen", 32'(bus.winscreen), 32'd0);
      idle();
      check("win.action",    32'(bus.action),    32'hFF);
      check("win.busy",      32'(bus.busy),      32'd0);
      check("win.winscreen", 32'(bus.winscreen), 32'd1);
      check("win.attempts",  32'(bus.attempts),  32'(att(3)));
      pulse(1'b1, 1'b1);
      check("win_pulses.action",    32'(bus.action),    32'hFF);
      check("win_pulses.winscreen", 32'(bus.winscreen), 32'd1);

      // reset in the middle of a hold
      apply_reset();
      expect_state("reset2", 8'h01, 0, 1'b0);
      check("reset2.winscreen", 32'(bus.winscreen), 32'd0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("mismatch2", 8'h0A, 1, 1'b1);
      idle();
      idle();
      apply_reset();
      expect_state("reset_in_hold", 8'h01, 0, 1'b0);
      check("reset_in_hold.attempts", 32'(bus.attempts), 32'd0);
      for (int i = 0; i < 6; i++) begin
         idle();
         expect_state("post_reset_idle", 8'h01, 0, 1'b0);
      end
      pulse(1'b0, 1'b1);
      expect_state("post_reset_pick0", 8'h02, 0, 1'b0);

      // clean full game {0,3}, {1,2} from reset
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("game_check1", 8'h82, 3, 1'b1);
      idle();
      expect_state("game_match1", 8'hC7, 1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      expect_state("game_check2", 8'hEB, 2, 1'b1);
      idle();
      check("game_win.action",    32'(bus.action),    32'hFF);
      check("game_win.winscreen", 32'(bus.winscreen), 32'd1);
      check("game_win.attempts",  32'(bus.attempts),  32'(att(2)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
